// File: rtl/led_fade_driver.sv
// -----------------------------------------------------------------------------
// led_fade_driver
// Turns per-LED on/off requests from the LED PIO into soft-ramped PWM drive.
// Each channel holds an 8-bit brightness level that walks toward 0 or 255 by
// STEP on every prescaled tick (or snaps instantly when fade_en=0); a shared
// free-running 8-bit PWM counter compares against each level to make led_out.
//
// Ports:
//   clk      in   1       system clock, single domain
//   reset_n  in   1       synchronous active-low reset
//   led_req  in   N_LEDS  per-LED request, 1 = on
//   fade_en  in   1       1 = ramped fade, 0 = instant on/off
//   led_out  out  N_LEDS  registered PWM drive (inverted if ACTIVE_LOW_OUT)
//   settled  out  1       every level equals its requested target
// -----------------------------------------------------------------------------
module led_fade_driver #(
    parameter int N_LEDS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int STEP           = 1,
    parameter int ACTIVE_LOW_OUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_req,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] led_out,
    output logic              settled
);

    localparam logic [15:0]       TICK_LAST = 16'(PRESCALE - 1);
    localparam logic [8:0]        STEP_W    = 9'(STEP);
    // Top of the PWM count is 254 so that level 255 compares as always-on.
    localparam logic [7:0]        PWM_LAST  = 8'd254;
    localparam logic              OUT_INV   = 1'(ACTIVE_LOW_OUT);
    localparam logic [N_LEDS-1:0] OUT_OFF   = {N_LEDS{OUT_INV}};

    logic [N_LEDS-1:0]      r_req_q;
    logic [15:0]            r_tick_cnt;
    logic [7:0]             r_pwm_cnt;
    logic [N_LEDS-1:0][7:0] r_level;
    logic [N_LEDS-1:0]      r_led_out;

    logic                   w_tick;
    logic [N_LEDS-1:0][7:0] w_level_nxt;
    logic [N_LEDS-1:0]      w_pwm_on;
    logic                   w_settled;

    // Saturating increment: 9-bit sum, clamp to 255 when it carries out.
    function automatic logic [7:0] sat_up(input logic [7:0] lvl);
        logic [8:0] sum;
        sum = {1'b0, lvl} + STEP_W;
        return sum[8] ? 8'd255 : sum[7:0];
    endfunction

    // Saturating decrement: a borrow into bit 8 means the result went below 0.
    function automatic logic [7:0] sat_dn(input logic [7:0] lvl);
        logic [8:0] diff;
        diff = {1'b0, lvl} - STEP_W;
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign led_out = r_led_out;
    assign settled = w_settled;

    // Next level per channel, PWM compare and settled detection.
    always_comb begin
        w_level_nxt = r_level;
        w_pwm_on    = '0;
        w_settled   = 1'b1;
        for (int i = 0; i < N_LEDS; i++) begin
            if (!fade_en) begin
                w_level_nxt[i] = r_req_q[i] ? 8'd255 : 8'd0;
            end else if (w_tick) begin
                w_level_nxt[i] = r_req_q[i] ? sat_up(r_level[i]) : sat_dn(r_level[i]);
            end else begin
                w_level_nxt[i] = r_level[i];
            end

            w_pwm_on[i] = (r_pwm_cnt < r_level[i]) ^ OUT_INV;

            if (r_level[i] != (r_req_q[i] ? 8'd255 : 8'd0)) begin
                w_settled = 1'b0;
            end else begin
                w_settled = w_settled;
            end
        end
    end

    // Input sampling, prescaler, PWM counter, levels and output drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req_q    <= '0;
            r_tick_cnt <= 16'd0;
            r_pwm_cnt  <= 8'd0;
            r_level    <= '0;
            r_led_out  <= OUT_OFF;
        end else begin
            r_req_q    <= led_req;
            r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
            r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? 8'd0 : r_pwm_cnt + 8'd1;
            r_level    <= w_level_nxt;
            r_led_out  <= w_pwm_on;
        end
    end

endmodule
